// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - dot-product sequencer driving one 3-stage mac processing element
//
// Purpose:
//   Runs one dot product of programmable length through an external mac.
//   Operand pairs arrive on a valid/ready stream and are forwarded straight
//   to the mac together with its load/mult/acc enables. The mac accumulator
//   is cleared at job start, and the final accumulator value is captured and
//   offered on a valid/ready result port.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset
//   start        begin a job (sampled only in IDLE)
//   len          number of operand pairs, sampled with start
//   in_a, in_b   operand pair
//   in_valid     operand pair valid
//   in_ready     sequencer accepts the pair (FEED only)
//   mac_a/mac_b  operands to the mac
//   mac_load_en  mac operand register enable
//   mac_mult_en  mac product register enable (load delayed 1 cycle)
//   mac_acc_en   mac accumulator enable (load delayed 2 cycles)
//   mac_reset_n  mac accumulator clear, active-low
//   mac_acc      mac accumulator output
//   res_data     captured dot-product result
//   res_valid    result valid (OUT)
//   res_ready    result consumer ready
//   busy         high whenever the sequencer is not IDLE

module mac_seq #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   mac_a,
  output logic [WIDTH-1:0]   mac_b,
  output logic               mac_load_en,
  output logic               mac_mult_en,
  output logic               mac_acc_en,
  output logic               mac_reset_n,
  input  logic [4*WIDTH-1:0] mac_acc,
  output logic [4*WIDTH-1:0] res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_nxt;
  logic [1:0]         drain_cnt;
  logic [1:0]         drain_cnt_nxt;
  logic [4*WIDTH-1:0] res_data_nxt;
  logic               mult_d;
  logic               acc_d;
  logic               accept;

  // Operands go to the mac untouched; the mac registers them on the load edge.
  assign mac_a = in_a;
  assign mac_b = in_b;

  assign in_ready    = (state == S_FEED);
  assign accept      = in_valid & in_ready;
  assign mac_load_en = accept;

  // Enable shift register matching the mac's load -> mult -> acc stages.
  // Bubbles on in_valid travel through as zeros, so gaps need no special care.
  assign mac_mult_en = mult_d;
  assign mac_acc_en  = acc_d;

  // The mac accumulator is cleared both by our reset and by the CLEAR state.
  assign mac_reset_n = reset & (state != S_CLEAR);

  assign res_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      res_data  <= '0;
      mult_d    <= 1'b0;
      acc_d     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      res_data  <= res_data_nxt;
      mult_d    <= mac_load_en;
      acc_d     <= mult_d;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    drain_cnt_nxt = drain_cnt;
    res_data_nxt  = res_data;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = len;
        end
      end

      // One cycle of mac_reset_n=0. A zero-length job skips FEED entirely.
      S_CLEAR: begin
        drain_cnt_nxt = 2'd0;
        if (cnt != '0) begin
          state_nxt = S_FEED;
        end else begin
          state_nxt = S_DRAIN;
        end
      end

      S_FEED: begin
        if (accept) begin
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state_nxt     = S_DRAIN;
            drain_cnt_nxt = 2'd0;
          end
        end
      end

      // Last load edge ends the final FEED cycle; mult follows one edge later,
      // acc one more, and acc_out is valid the cycle after that. That is the
      // third DRAIN cycle, so capture happens on the edge that ends it.
      S_DRAIN: begin
        if (drain_cnt == 2'd2) begin
          res_data_nxt = mac_acc;
          state_nxt    = S_OUT;
        end else begin
          drain_cnt_nxt = drain_cnt + 2'd1;
        end
      end

      S_OUT: begin
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
